// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of every requester-side and controller-side signal around the
// I2C bus arbiter. The arbiter connects through the master modport and the
// environment (requesters plus serial controller) through the slave modport.
interface i2c_bus_arbiter_if;
    // requester 0 (auto-init engine)
    logic [7:0] rq0_data;
    logic [2:0] rq0_size;
    logic       rq0_transfer_data;
    logic       rq0_send_start_bit;
    logic       rq0_send_stop_bit;
    logic       rq0_ack;
    logic       rq0_transfer_complete;
    logic       rq0_granted;
    // requester 1 (host command port)
    logic [7:0] rq1_data;
    logic [2:0] rq1_size;
    logic       rq1_transfer_data;
    logic       rq1_send_start_bit;
    logic       rq1_send_stop_bit;
    logic       rq1_ack;
    logic       rq1_transfer_complete;
    logic       rq1_granted;
    // serial controller side
    logic       ack;
    logic       transfer_complete;
    logic [7:0] data_out;
    logic [2:0] data_size;
    logic       transfer_data;
    logic       send_start_bit;
    logic       send_stop_bit;

    modport master (
        input  rq0_data, rq0_size, rq0_transfer_data, rq0_send_start_bit, rq0_send_stop_bit,
        input  rq1_data, rq1_size, rq1_transfer_data, rq1_send_start_bit, rq1_send_stop_bit,
        input  ack, transfer_complete,
        output rq0_ack, rq0_transfer_complete, rq0_granted,
        output rq1_ack, rq1_transfer_complete, rq1_granted,
        output data_out, data_size, transfer_data, send_start_bit, send_stop_bit
    );

    modport slave (
        output rq0_data, rq0_size, rq0_transfer_data, rq0_send_start_bit, rq0_send_stop_bit,
        output rq1_data, rq1_size, rq1_transfer_data, rq1_send_start_bit, rq1_send_stop_bit,
        output ack, transfer_complete,
        input  rq0_ack, rq0_transfer_complete, rq0_granted,
        input  rq1_ack, rq1_transfer_complete, rq1_granted,
        input  data_out, data_size, transfer_data, send_start_bit, send_stop_bit
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Two-requester arbiter in front of one I2C serial controller. Ownership is
// held from start bit to stop bit; ties alternate. A watchdog forces a stop
// bit when the owner sits idle for TIMEOUT_CYCLES cycles.
module i2c_bus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_error,
    i2c_bus_arbiter_if.master  bus,
    output logic               bus_busy,
    output logic               timeout_error
);
    typedef enum logic [1:0] {IDLE, OWNED, ABORT_STOP, RELEASE} state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic [1:0]  grant_q;
    logic [15:0] wd_cnt_q;
    logic        timeout_error_q;

    // requester inputs gathered into arrays so the owner can index them
    logic [7:0] rq_data [2];
    logic [2:0] rq_size [2];
    logic [1:0] rq_td;
    logic [1:0] rq_st;
    logic [1:0] rq_sp;
    logic [1:0] rq_ack_v;
    logic [1:0] rq_tc_v;

    assign rq_data[0] = bus.rq0_data;
    assign rq_data[1] = bus.rq1_data;
    assign rq_size[0] = bus.rq0_size;
    assign rq_size[1] = bus.rq1_size;
    assign rq_td      = {bus.rq1_transfer_data,  bus.rq0_transfer_data};
    assign rq_st      = {bus.rq1_send_start_bit, bus.rq0_send_start_bit};
    assign rq_sp      = {bus.rq1_send_stop_bit,  bus.rq0_send_stop_bit};

    logic owner_idle;
    logic release_req;
    logic wd_hit;
    logic pick;

    assign owner_idle  = ~(rq_td[owner_q] | rq_st[owner_q] | rq_sp[owner_q]);
    assign release_req = rq_sp[owner_q] & bus.transfer_complete;
    assign wd_hit      = (TIMEOUT_CYCLES != 16'd0) && owner_idle &&
                         (wd_cnt_q == TIMEOUT_CYCLES - 16'd1);
    // on a tie the requester that did not own last wins; otherwise whoever asks
    assign pick        = (rq_st[0] & rq_st[1]) ? ~last_owner_q : ~rq_st[0];

    // arbitration FSM, grants, watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            grant_q         <= 2'b00;
            wd_cnt_q        <= 16'd0;
            timeout_error_q <= 1'b0;
        end else begin
            if (clear_error)
                timeout_error_q <= 1'b0;

            if (state_q == OWNED && owner_idle)
                wd_cnt_q <= (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
            else
                wd_cnt_q <= 16'd0;

            case (state_q)
                IDLE: begin
                    if (|rq_st) begin
                        state_q      <= OWNED;
                        owner_q      <= pick;
                        last_owner_q <= pick;
                        grant_q      <= pick ? 2'b10 : 2'b01;
                    end
                end
                OWNED: begin
                    if (release_req) begin
                        state_q <= RELEASE;
                        grant_q <= 2'b00;
                    end else if (wd_hit) begin
                        state_q         <= ABORT_STOP;
                        grant_q         <= 2'b00;
                        timeout_error_q <= 1'b1;
                    end
                end
                ABORT_STOP: begin
                    if (bus.transfer_complete)
                        state_q <= RELEASE;
                end
                RELEASE: begin
                    // wait for complete to fall so the next owner never sees it stale
                    if (!bus.transfer_complete)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // controller command mux: owner passes straight through, abort forces a stop
    always_comb begin
        bus.data_out       = 8'd0;
        bus.data_size      = 3'd0;
        bus.transfer_data  = 1'b0;
        bus.send_start_bit = 1'b0;
        bus.send_stop_bit  = 1'b0;
        case (state_q)
            OWNED: begin
                bus.data_out       = rq_data[owner_q];
                bus.data_size      = rq_size[owner_q];
                bus.transfer_data  = rq_td[owner_q];
                bus.send_start_bit = rq_st[owner_q];
                bus.send_stop_bit  = rq_sp[owner_q];
            end
            ABORT_STOP: bus.send_stop_bit = 1'b1;
            default: ;
        endcase
    end

    // controller responses are routed only to the current owner
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign rq_ack_v[gi] = grant_q[gi] & bus.ack;
        assign rq_tc_v[gi]  = grant_q[gi] & bus.transfer_complete;
    end

    assign bus.rq0_ack               = rq_ack_v[0];
    assign bus.rq1_ack               = rq_ack_v[1];
    assign bus.rq0_transfer_complete = rq_tc_v[0];
    assign bus.rq1_transfer_complete = rq_tc_v[1];
    assign bus.rq0_granted           = grant_q[0];
    assign bus.rq1_granted           = grant_q[1];
    assign bus_busy                  = (state_q != IDLE);
    assign timeout_error             = timeout_error_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for the I2C bus arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural ownership model.
module tb_i2c_bus_arbiter;
    localparam int TO = 8;
    localparam int PH_FREE = 0, PH_HELD = 1, PH_ABORT = 2, PH_DRAIN = 3;

    logic clk = 1'b0;
    logic reset, clear_error;
    logic [7:0] d0, d1;
    logic [2:0] sz0, sz1;
    logic td0, td1, st0, st1, sp0, sp1;
    logic ack, tc;
    logic bus_busy, timeout_error;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of who holds the bus
    int m_phase, m_owner, m_last, m_wd;
    bit m_terr;

    i2c_bus_arbiter_if bif();

    assign bif.rq0_data           = d0;
    assign bif.rq1_data           = d1;
    assign bif.rq0_size           = sz0;
    assign bif.rq1_size           = sz1;
    assign bif.rq0_transfer_data  = td0;
    assign bif.rq1_transfer_data  = td1;
    assign bif.rq0_send_start_bit = st0;
    assign bif.rq1_send_start_bit = st1;
    assign bif.rq0_send_stop_bit  = sp0;
    assign bif.rq1_send_stop_bit  = sp1;
    assign bif.ack                = ack;
    assign bif.transfer_complete  = tc;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(16'(TO))) dut (
        .clk           (clk),
        .reset         (reset),
        .clear_error   (clear_error),
        .bus           (bif),
        .bus_busy      (bus_busy),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] owner_cmd(input int who);
        if (who == 0) return {d0, sz0, td0, st0, sp0};
        return {d1, sz1, td1, st1, sp1};
    endfunction

    // compare every observable output against what the model implies now
    task automatic check_all();
        logic [1:0]  eg;
        logic [13:0] ec;
        eg = (m_phase == PH_HELD) ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
        ec = (m_phase == PH_HELD)  ? owner_cmd(m_owner) :
             (m_phase == PH_ABORT) ? 14'd1 : 14'd0;
        check_eq("grants", {30'd0, bif.rq1_granted, bif.rq0_granted}, {30'd0, eg});
        check_eq("ctrl_cmd", {18'd0, bif.data_out, bif.data_size, bif.transfer_data,
                 bif.send_start_bit, bif.send_stop_bit}, {18'd0, ec});
        check_eq("responses", {28'd0, bif.rq1_ack, bif.rq1_transfer_complete, bif.rq0_ack,
                 bif.rq0_transfer_complete}, {28'd0, ack & eg[1], tc & eg[1], ack & eg[0], tc & eg[0]});
        check_eq("bus_busy", {31'd0, bus_busy}, {31'd0, m_phase != PH_FREE});
        check_eq("timeout_error", {31'd0, timeout_error}, {31'd0, m_terr});
    endtask

    // advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        int  np;
        bit  nterr, o_idle, o_sp;
        if (reset) begin
            m_phase = PH_FREE; m_owner = 0; m_last = 1; m_wd = 0; m_terr = 0;
            return;
        end
        np    = m_phase;
        nterr = clear_error ? 1'b0 : m_terr;
        o_idle = (owner_cmd(m_owner) & 14'h7) == 0;
        o_sp   = (m_owner == 0) ? sp0 : sp1;
        if (m_phase == PH_FREE) begin
            if (st0 || st1) begin
                m_owner = (st0 && st1) ? 1 - m_last : (st0 ? 0 : 1);
                m_last  = m_owner;
                np      = PH_HELD;
            end
        end else if (m_phase == PH_HELD) begin
            if (o_sp && tc) np = PH_DRAIN;
            else if (TO != 0 && o_idle && m_wd == TO - 1) begin
                np = PH_ABORT; nterr = 1;
            end
        end else if (m_phase == PH_ABORT) begin
            if (tc) np = PH_DRAIN;
        end else begin
            if (!tc) np = PH_FREE;
        end
        m_wd    = (m_phase == PH_HELD && o_idle) ? ((m_wd < 65535) ? m_wd + 1 : m_wd) : 0;
        m_phase = np;
        m_terr  = nterr;
    endtask

    task automatic run_cycle();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic clr_inputs();
        reset = 0; clear_error = 0;
        d0 = 0; d1 = 0; sz0 = 0; sz1 = 0;
        td0 = 0; td1 = 0; st0 = 0; st1 = 0; sp0 = 0; sp1 = 0;
        ack = 0; tc = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1;
        run_cycle();
        reset = 0;
    endtask

    initial begin
        clr_inputs();
        reset = 1;
        m_phase = PH_FREE; m_owner = 0; m_last = 1; m_wd = 0; m_terr = 0;
        repeat (2) @(posedge clk);
        #1;
        run_cycle();
        check_eq("reset_busy", {31'd0, bus_busy}, 32'd0);
        reset = 0;
        $display("reset: outputs idle");

        // single rq0 transaction: start, two bytes, stop, lingering complete
        st0 = 1;
        run_cycle();
        check_eq("rq0_grant_plus1", {30'd0, bif.rq1_granted, bif.rq0_granted}, 32'd1);
        st0 = 0; td0 = 1; d0 = 8'hA5; sz0 = 3'd7;
        run_cycle();
        check_eq("data_follows_rq0", {24'd0, bif.data_out}, 32'hA5);
        tc = 1; ack = 1; run_cycle();
        tc = 0; ack = 0; d0 = 8'h3C; run_cycle();
        tc = 1; run_cycle();
        td0 = 0; tc = 0; sp0 = 1; run_cycle();
        tc = 1; run_cycle();
        sp0 = 0;
        run_n(5);
        check_eq("release_holds", {31'd0, bus_busy}, 32'd1);
        tc = 0; run_cycle();
        check_eq("release_to_idle", {31'd0, bus_busy}, 32'd0);
        $display("txn rq0 two-byte write done");

        // tie after reset goes to rq0, the next tie to rq1
        do_reset();
        st0 = 1; st1 = 1; run_cycle();
        check_eq("tie1_rq0", {30'd0, bif.rq1_granted, bif.rq0_granted}, 32'd1);
        st0 = 0; st1 = 0; sp0 = 1; tc = 1; run_cycle();
        sp0 = 0; tc = 0; run_cycle();
        st0 = 1; st1 = 1; run_cycle();
        check_eq("tie2_rq1", {30'd0, bif.rq1_granted, bif.rq0_granted}, 32'd2);
        st0 = 0; st1 = 0; sp1 = 1; tc = 1; run_cycle();
        sp1 = 0; tc = 0; run_cycle();
        $display("txn tie arbitration done");

        // rq1 waits while rq0 owns, then is served after release
        do_reset();
        st0 = 1; run_cycle();
        st0 = 0; st1 = 1; td0 = 1; d1 = 8'h77;
        for (int i = 0; i < 6; i++) begin
            tc = i[0]; ack = ~i[0];
            run_cycle();
        end
        td0 = 0; sp0 = 1; tc = 1; run_cycle();
        sp0 = 0; tc = 0; ack = 0; run_cycle();
        check_eq("pending_not_yet", {31'd0, bif.rq1_granted}, 32'd0);
        run_cycle();
        check_eq("pending_served", {30'd0, bif.rq1_granted, bif.rq0_granted}, 32'd2);
        st1 = 0; sp1 = 1; tc = 1; run_cycle();
        sp1 = 0; tc = 0; run_cycle();
        $display("txn pending requester done");

        // watchdog: owner goes quiet for TO cycles
        do_reset();
        st0 = 1; run_cycle();
        st0 = 0;
        run_n(TO - 1);
        check_eq("wd_not_yet", {31'd0, bif.rq0_granted}, 32'd1);
        run_cycle();
        check_eq("wd_stop", {31'd0, bif.send_stop_bit}, 32'd1);
        check_eq("wd_error", {31'd0, timeout_error}, 32'd1);
        check_eq("wd_grant_drop", {31'd0, bif.rq0_granted}, 32'd0);
        tc = 1; run_cycle();
        tc = 0; run_cycle();
        clear_error = 1; run_cycle();
        clear_error = 0;
        check_eq("wd_cleared", {31'd0, timeout_error}, 32'd0);
        run_cycle();
        $display("txn watchdog abort done");

        // reset in the middle of a byte, then a fresh rq1 start
        st1 = 1; run_cycle();
        st1 = 0; td1 = 1; d1 = 8'h5A; run_cycle();
        reset = 1; run_cycle();
        reset = 0;
        check_eq("midreset_idle", {29'd0, bus_busy, bif.rq1_granted, bif.transfer_data}, 32'd0);
        td1 = 0; st1 = 1; run_cycle();
        check_eq("post_reset_rq1", {30'd0, bif.rq1_granted, bif.rq0_granted}, 32'd2);
        $display("txn mid-operation reset done");

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            clear_error = ($urandom_range(0, 19) == 0);
            d0 = 8'($urandom); d1 = 8'($urandom);
            sz0 = 3'($urandom); sz1 = 3'($urandom);
            td0 = ($urandom_range(0, 9) == 0); td1 = ($urandom_range(0, 9) == 0);
            st0 = ($urandom_range(0, 7) == 0); st1 = ($urandom_range(0, 7) == 0);
            sp0 = ($urandom_range(0, 9) == 0); sp1 = ($urandom_range(0, 9) == 0);
            ack = $urandom_range(0, 1) == 1;
            tc  = ($urandom_range(0, 3) == 0);
            run_cycle();
        end
        $display("txn random traffic done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
